// File: rtl/data_mem_bus.sv
// CPU data-side bus: word RAM, LED register and free-running cycle counter, 1-cycle read latency.
// Optional macro ADDR_CHECK_EN enables unmapped/misaligned access trapping with a sticky Bus_Err.
module data_mem_bus #(
    parameter int unsigned RAM_WORDS = 256,
    parameter logic [31:0] IO_BASE   = 32'h0000_1000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] ADDR,
    input  logic [31:0] Data_BUS_WRITE,
    input  logic        CS,
    input  logic        WR_RD,
    output logic [31:0] Data_BUS_READ,
    output logic [31:0] LED_OUT,
    output logic        Bus_Err
);

    localparam int unsigned AW = $clog2(4 * RAM_WORDS);
    localparam int unsigned IW = AW - 2;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    logic [31:0]   mem [RAM_WORDS];
    logic [31:0]   rd_q;
    logic [31:0]   led_q;
    logic [31:0]   cnt_q;
    logic          err_q;

    logic          sel_ram;
    logic          sel_led;
    logic          sel_cnt;
    logic          bad;
    logic [IW-1:0] widx;
    logic [31:0]   rd_data;

    always_comb begin
        sel_ram = ADDR < 32'(4 * RAM_WORDS);
        // RAM wins if a mis-parameterised IO_BASE ever overlaps it
        sel_led = !sel_ram && (ADDR[31:2] == IO_BASE[31:2]);
        sel_cnt = !sel_ram && (ADDR[31:2] == IO_BASE[31:2] + 30'd1);
`ifdef ADDR_CHECK_EN
        bad = (ADDR[1:0] != 2'b00) || !(sel_ram || sel_led || sel_cnt);
`else
        bad = 1'b0;
`endif
        widx = ADDR[AW-1:2];
        rd_data = 32'h0;
        if (sel_ram) begin
            rd_data = mem[widx];
        end else if (sel_led) begin
            rd_data = led_q;
        end else if (sel_cnt) begin
            rd_data = cnt_q;
        end
    end

    // RAM has no reset; contents survive Reset
    always_ff @(posedge Clk) begin
        if (!Reset && CS && WR_RD && sel_ram && !bad) begin
            mem[widx] <= Data_BUS_WRITE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_q  <= 32'h0;
            led_q <= 32'h0;
            cnt_q <= 32'h0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
            if (CS) begin
                if (bad) begin
                    err_q <= 1'b1;
                    if (!WR_RD) begin
                        rd_q <= ERR_WORD;
                    end
                end else if (WR_RD) begin
                    if (sel_led) begin
                        led_q <= Data_BUS_WRITE;
                    end
                    // clear overrides the increment above
                    if (sel_cnt) begin
                        cnt_q <= 32'h0;
                    end
                end else begin
                    rd_q <= rd_data;
                end
            end
        end
    end

    assign Data_BUS_READ = rd_q;
    assign LED_OUT       = led_q;
    assign Bus_Err       = err_q;

endmodule

// File: tb/tb_data_mem_bus.sv
// Bench for data_mem_bus: directed literal checks plus randomized traffic against a behavioural model.
module tb_data_mem_bus;

    localparam int unsigned RAM_WORDS = 256;
    localparam logic [31:0] IO_BASE   = 32'h0000_1000;
`ifdef ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        Clk;
    logic        Reset;
    logic [31:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic        CS;
    logic        WR_RD;
    logic [31:0] Data_BUS_READ;
    logic [31:0] LED_OUT;
    logic        Bus_Err;

    data_mem_bus #(
        .RAM_WORDS(RAM_WORDS),
        .IO_BASE  (IO_BASE)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ADDR          (ADDR),
        .Data_BUS_WRITE(Data_BUS_WRITE),
        .CS            (CS),
        .WR_RD         (WR_RD),
        .Data_BUS_READ (Data_BUS_READ),
        .LED_OUT       (LED_OUT),
        .Bus_Err       (Bus_Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;
    bit wrap_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the bus must show, derived from the address map rules
    logic [31:0] m_ram [RAM_WORDS];
    bit          m_wr  [RAM_WORDS];
    logic [31:0] m_rd, m_led, m_cnt, pre, wa;
    bit          m_known, m_err, in_ram, in_led, in_cnt, m_bad;
    int          idx;

    initial begin
        for (int i = 0; i < int'(RAM_WORDS); i++) m_wr[i] = 1'b0;
    end

    always @(posedge Clk) begin
        if (wrap_req) m_cnt = 32'hFFFF_FFFF;
        if (Reset) begin
            m_rd = 0; m_known = 1; m_led = 0; m_cnt = 0; m_err = 0;
        end else begin
            pre = m_cnt;
            m_cnt = m_cnt + 1;
            if (CS) begin
                wa     = {ADDR[31:2], 2'b00};
                in_ram = ADDR < 4 * RAM_WORDS;
                in_led = !in_ram && wa == IO_BASE;
                in_cnt = !in_ram && wa == IO_BASE + 4;
                m_bad  = CHK && (ADDR[1:0] != 0 || !(in_ram || in_led || in_cnt));
                idx    = int'((ADDR >> 2) % RAM_WORDS);
                if (m_bad) begin
                    m_err = 1;
                    if (!WR_RD) begin m_rd = 32'hDEAD_BEEF; m_known = 1; end
                end else if (WR_RD) begin
                    if (in_ram) begin m_ram[idx] = Data_BUS_WRITE; m_wr[idx] = 1; end
                    else if (in_led) m_led = Data_BUS_WRITE;
                    else if (in_cnt) m_cnt = 0;
                end else begin
                    m_known = 1;
                    if (in_ram) begin m_rd = m_ram[idx]; m_known = m_wr[idx]; end
                    else if (in_led) m_rd = m_led;
                    else if (in_cnt) m_rd = pre;
                    else m_rd = 0;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_on) begin
            if (m_known) check("model_rd", Data_BUS_READ, m_rd);
            check("model_led", LED_OUT, m_led);
            check("model_err", {31'b0, Bus_Err}, {31'b0, m_err});
        end
    end

    task automatic cycle(input logic rst, input logic cs, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        Reset = rst; CS = cs; WR_RD = wr; ADDR = a; Data_BUS_WRITE = d;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    logic [31:0] ra, rd_v;
    int          sel;

    initial begin
        Reset = 1'b1; CS = 1'b0; WR_RD = 1'b0; ADDR = 32'h0; Data_BUS_WRITE = 32'h0;
        cycle(1, 1, 1, IO_BASE, 32'h1111_1111);
        cycle(1, 1, 0, IO_BASE, 32'h0);
        chk_on = 1'b1;
        check("reset_rd", Data_BUS_READ, 32'h0);
        check("reset_led", LED_OUT, 32'h0);
        check("reset_err", {31'b0, Bus_Err}, 32'h0);

        // counter: edge n after release returns n-1
        idle(1);
        cycle(0, 1, 0, IO_BASE + 4, 0);
        check("cnt_first", Data_BUS_READ, 32'd1);
        idle(8);
        cycle(0, 1, 0, IO_BASE + 4, 0);
        check("cnt_ten", Data_BUS_READ, 32'd10);
        cycle(0, 1, 1, IO_BASE + 4, 32'hFFFF_0000);
        cycle(0, 1, 0, IO_BASE + 4, 0);
        check("cnt_clear", Data_BUS_READ, 32'd0);

        // RAM
        cycle(0, 1, 1, 32'h10, 32'h1234_5678);
        cycle(0, 1, 0, 32'h10, 0);
        check("ram_10", Data_BUS_READ, 32'h1234_5678);
        cycle(0, 1, 1, 32'h14, 32'hA5A5_A5A5);
        cycle(0, 1, 0, 32'h14, 0);
        check("ram_14", Data_BUS_READ, 32'hA5A5_A5A5);

        // LED
        cycle(0, 1, 1, IO_BASE, 32'h0000_00FF);
        check("led_out", LED_OUT, 32'h0000_00FF);
        cycle(0, 1, 0, IO_BASE, 0);
        check("led_read", Data_BUS_READ, 32'h0000_00FF);
        cycle(0, 1, 1, 32'h20, 32'h0BAD_F00D);
        check("rd_hold", Data_BUS_READ, 32'h0000_00FF);
        cycle(1, 0, 0, 0, 0);
        check("led_reset", LED_OUT, 32'h0);

        // unmapped
        cycle(0, 1, 0, 32'h0000_2000, 0);
        check("unmap_rd", Data_BUS_READ, CHK ? 32'hDEAD_BEEF : 32'h0);
        check("unmap_err", {31'b0, Bus_Err}, {31'b0, CHK});
        idle(3);
        check("unmap_err_held", {31'b0, Bus_Err}, {31'b0, CHK});
        cycle(1, 0, 0, 0, 0);

        // misaligned write
        cycle(0, 1, 1, 32'h11, 32'hCAFE_0001);
        cycle(0, 1, 0, 32'h10, 0);
        check("misal_rd", Data_BUS_READ, CHK ? 32'h1234_5678 : 32'hCAFE_0001);
        check("misal_err", {31'b0, Bus_Err}, {31'b0, CHK});

        // reset right after a read request
        cycle(0, 1, 0, 32'h14, 0);
        check("pre_cancel_rd", Data_BUS_READ, 32'hA5A5_A5A5);
        cycle(1, 1, 0, 32'h14, 0);
        check("cancel_rd", Data_BUS_READ, 32'h0);
        idle(2);
        check("cancel_after", Data_BUS_READ, 32'h0);

        // counter wrap
        force dut.cnt_q = 32'hFFFF_FFFF;
        wrap_req = 1'b1;
        #1;
        release dut.cnt_q;
        cycle(0, 1, 0, IO_BASE + 4, 0);
        wrap_req = 1'b0;
        check("wrap_max", Data_BUS_READ, 32'hFFFF_FFFF);
        cycle(0, 1, 0, IO_BASE + 4, 0);
        check("wrap_zero", Data_BUS_READ, 32'h0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 11));
            case (sel)
                0, 1, 2, 3, 4: ra = $urandom_range(0, 15) * 4;
                5:             ra = $urandom_range(0, 4 * RAM_WORDS - 1);
                6:             ra = IO_BASE | ($urandom_range(0, 7) == 0 ? $urandom_range(1, 3) : 0);
                7:             ra = (IO_BASE + 4) | ($urandom_range(0, 7) == 0 ? $urandom_range(1, 3) : 0);
                8:             ra = IO_BASE + 8 + 4 * $urandom_range(0, 1);
                9:             ra = $urandom;
                default:       ra = $urandom_range(0, RAM_WORDS - 1) * 4;
            endcase
            rd_v = $urandom;
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  ra, rd_v);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
